// File: rtl/led_breath_sequencer_pkg.sv
// Shared encodings for the LED breathing sequencer: FSM phase values and
// channel pattern selectors.
package led_breath_sequencer_pkg;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_RAMP_UP   = 3'd1,
        PH_HOLD_HIGH = 3'd2,
        PH_RAMP_DOWN = 3'd3,
        PH_HOLD_LOW  = 3'd4
    } phase_e;

    localparam logic [1:0] MODE_INPHASE = 2'd0;
    localparam logic [1:0] MODE_SPLIT   = 2'd1;
    localparam logic [1:0] MODE_CHASE   = 2'd2;

    // The unused encoding 3 behaves as in-phase.
    function automatic logic [1:0] decode_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_INPHASE : m;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: registered compare of the shared PWM counter against this
// channel's duty, forced low while off is asserted.
module led_pwm_channel
    import led_breath_sequencer_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             off,
    input  logic [WIDTH-1:0] pcount,
    input  logic [WIDTH-1:0] duty,
    output logic             led
);

    logic led_d, led_q;

    always_comb begin
        led_d = !off && (pcount < duty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led_q <= 1'b0;
        else        led_q <= led_d;
    end

    assign led = led_q;

endmodule

// File: rtl/led_breath_sequencer.sv
// Breathing LED sequencer: free-running PWM counter, ramp/hold duty profile
// stepped once per PWM period, and in-phase / split / chase channel mapping.
module led_breath_sequencer
    import led_breath_sequencer_pkg::*;
#(
    parameter int WIDTH        = 12,
    parameter int NUM_LEDS     = 8,
    parameter int MIN_DUTY     = 16,
    parameter int MAX_DUTY     = 4095,
    parameter int STEP         = 1,
    parameter int HOLD_PERIODS = 64
) (
    input  logic                clk,
    input  logic                NOTRESET,
    input  logic                enable,
    input  logic [1:0]          mode,
    output logic [NUM_LEDS-1:0] LED,
    output logic [2:0]          phase,
    output logic                cycle_done
);

    localparam int HW = $clog2(HOLD_PERIODS + 1);
    localparam int CW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam logic [WIDTH-1:0] DMIN = WIDTH'(MIN_DUTY);
    localparam logic [WIDTH-1:0] DMAX = WIDTH'(MAX_DUTY);

    phase_e                       state_q, state_d;
    logic [WIDTH-1:0]             pcount_q, pcount_d;
    logic [WIDTH-1:0]             duty_q, duty_d;
    logic [HW-1:0]                hold_q, hold_d;
    logic [CW-1:0]                chase_q, chase_d;
    logic [1:0]                   mode_q, mode_d;
    logic                         cycle_done_q, cycle_done_d;

    logic                         boundary, hold_last, up_sat, dn_floor, led_off;
    logic [WIDTH:0]               up_sum;
    logic signed [WIDTH+1:0]      dn_diff;
    logic [WIDTH-1:0]             duty_up, duty_dn, split_duty;
    logic [NUM_LEDS-1:0][WIDTH-1:0] chan_duty;

    // Saturating step arithmetic: up in WIDTH+1 bits, down signed so a
    // small duty cannot wrap below MIN_DUTY.
    always_comb begin
        pcount_d  = pcount_q + 1'b1;
        boundary  = &pcount_q;
        up_sum    = {1'b0, duty_q} + (WIDTH+1)'(STEP);
        up_sat    = up_sum >= {1'b0, DMAX};
        duty_up   = up_sat ? DMAX : up_sum[WIDTH-1:0];
        dn_diff   = $signed({2'b00, duty_q}) - $signed((WIDTH+2)'(STEP));
        dn_floor  = dn_diff <= $signed({2'b00, DMIN});
        duty_dn   = dn_floor ? DMIN : dn_diff[WIDTH-1:0];
        hold_last = (hold_q + 1'b1) == HW'(HOLD_PERIODS);
    end

    always_ff @(posedge clk or negedge NOTRESET) begin
        if (!NOTRESET) state_q <= PH_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = PH_IDLE;
        end else if (boundary) begin
            case (state_q)
                PH_IDLE:      state_d = PH_RAMP_UP;
                PH_RAMP_UP:   if (up_sat)    state_d = PH_HOLD_HIGH;
                PH_HOLD_HIGH: if (hold_last) state_d = PH_RAMP_DOWN;
                PH_RAMP_DOWN: if (dn_floor)  state_d = PH_HOLD_LOW;
                PH_HOLD_LOW:  if (hold_last) state_d = PH_RAMP_UP;
                default:      state_d = PH_IDLE;
            endcase
        end
    end

    // Everything except pcount moves only on a period boundary, so the
    // compare never sees a mid-period duty change.
    always_comb begin
        duty_d       = duty_q;
        hold_d       = hold_q;
        chase_d      = chase_q;
        mode_d       = mode_q;
        cycle_done_d = 1'b0;
        if (!enable) begin
            duty_d  = DMIN;
            hold_d  = '0;
            chase_d = '0;
        end else if (boundary) begin
            case (state_q)
                PH_IDLE: mode_d = mode;
                PH_RAMP_UP: begin
                    duty_d = duty_up;
                    hold_d = '0;
                end
                PH_HOLD_HIGH: begin
                    hold_d = hold_q + 1'b1;
                    if (hold_last) begin
                        duty_d = duty_dn;
                        hold_d = '0;
                    end
                end
                PH_RAMP_DOWN: begin
                    duty_d = duty_dn;
                    hold_d = '0;
                end
                PH_HOLD_LOW: begin
                    hold_d = hold_q + 1'b1;
                    if (hold_last) begin
                        duty_d       = duty_up;
                        hold_d       = '0;
                        mode_d       = mode;
                        cycle_done_d = 1'b1;
                        chase_d      = (chase_q == CW'(NUM_LEDS - 1)) ? '0 : chase_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge NOTRESET) begin
        if (!NOTRESET) begin
            pcount_q     <= '0;
            duty_q       <= DMIN;
            hold_q       <= '0;
            chase_q      <= '0;
            mode_q       <= MODE_INPHASE;
            cycle_done_q <= 1'b0;
        end else begin
            pcount_q     <= pcount_d;
            duty_q       <= duty_d;
            hold_q       <= hold_d;
            chase_q      <= chase_d;
            mode_q       <= mode_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    // Gating on enable as well as state blanks the LEDs on the same edge
    // that drops the FSM to IDLE.
    always_comb begin
        phase      = state_q;
        cycle_done = cycle_done_q;
        led_off    = !enable || (state_q == PH_IDLE);
        split_duty = DMAX + DMIN - duty_q;
        for (int i = 0; i < NUM_LEDS; i++) begin
            chan_duty[i] = duty_q;
            case (decode_mode(mode_q))
                MODE_SPLIT: if (i >= NUM_LEDS / 2) chan_duty[i] = split_duty;
                MODE_CHASE: if (chase_q != CW'(i)) chan_duty[i] = '0;
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        led_pwm_channel #(.WIDTH(WIDTH)) u_chan (
            .clk    (clk),
            .rst_n  (NOTRESET),
            .off    (led_off),
            .pcount (pcount_q),
            .duty   (chan_duty[g]),
            .led    (LED[g])
        );
    end

endmodule

// File: tb/tb_led_breath_sequencer.sv
// Bench for led_breath_sequencer: two instances (STEP=4 and STEP=5) checked every
// clk against a period-level breath profile model plus spec-level high-time tables.
module tb_led_breath_sequencer;

    localparam int N   = 8;
    localparam int MN  = 2;
    localparam int MX  = 14;
    localparam int HP  = 2;
    localparam int PER = 16;
    localparam int VW  = 2 * (N + 4);

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en0 = 1'b0, en1 = 1'b0;
    logic [1:0]   md0 = 2'd0, md1 = 2'd0;
    logic [N-1:0] led0, led1;
    logic [2:0]   ph0, ph1;
    logic         cd0, cd1;
    logic [VW-1:0] act;

    always #5 clk = ~clk;

    led_breath_sequencer #(.WIDTH(4), .NUM_LEDS(N), .MIN_DUTY(MN), .MAX_DUTY(MX),
                           .STEP(4), .HOLD_PERIODS(HP)) dut0 (
        .clk(clk), .NOTRESET(rst_n), .enable(en0), .mode(md0),
        .LED(led0), .phase(ph0), .cycle_done(cd0));

    led_breath_sequencer #(.WIDTH(4), .NUM_LEDS(N), .MIN_DUTY(MN), .MAX_DUTY(MX),
                           .STEP(5), .HOLD_PERIODS(HP)) dut1 (
        .clk(clk), .NOTRESET(rst_n), .enable(en1), .mode(md1),
        .LED(led1), .phase(ph1), .cycle_done(cd1));

    assign act = {led0, ph0, cd0, led1, ph1, cd1};

    int checks = 0;
    int errors = 0;

    // Model: one breath is a list of (duty, phase) per PWM period; the first lit
    // period after IDLE is (MIN,1), after which the list repeats forever.
    int           stp[2] = '{4, 5};
    int           cyc_d[2][64];
    int           cyc_p[2][64];
    int           clen[2];
    int           m_pc[2], m_idx[2], m_chase[2], m_last[2];
    bit           m_run[2];
    logic [1:0]   m_mode[2];
    logic [N-1:0] exp_led[2];
    logic [2:0]   exp_ph[2];
    logic         exp_cd[2];

    task automatic build_profile(input int k);
        int v;
        int n;
        v = MN;
        n = 0;
        do begin
            v = (v + stp[k] > MX) ? MX : v + stp[k];
            cyc_d[k][n] = v; cyc_p[k][n] = (v == MX) ? 2 : 1; n++;
        end while (v != MX);
        repeat (HP - 1) begin cyc_d[k][n] = MX; cyc_p[k][n] = 2; n++; end
        do begin
            v = (v - stp[k] < MN) ? MN : v - stp[k];
            cyc_d[k][n] = v; cyc_p[k][n] = (v == MN) ? 4 : 3; n++;
        end while (v != MN);
        repeat (HP - 1) begin cyc_d[k][n] = MN; cyc_p[k][n] = 4; n++; end
        clen[k] = n;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_idx[k] = 0; m_chase[k] = 0; m_last[k] = 0;
            m_run[k] = 1'b0; m_mode[k] = 2'd0;
            exp_led[k] = '0; exp_ph[k] = 3'd0; exp_cd[k] = 1'b0;
        end
    endtask

    function automatic int cur_duty(input int k);
        return (m_idx[k] == 0) ? MN : cyc_d[k][(m_idx[k] - 1) % clen[k]];
    endfunction

    function automatic int cur_ph(input int k);
        return (m_idx[k] == 0) ? 1 : cyc_p[k][(m_idx[k] - 1) % clen[k]];
    endfunction

    function automatic int chan_d(input int k, input int i);
        int d;
        d = cur_duty(k);
        if (m_mode[k] == 2'd1 && i >= N / 2) return MX + MN - d;
        if (m_mode[k] == 2'd2) return (i == m_chase[k]) ? d : 0;
        return d;
    endfunction

    task automatic model_step(input int k, input logic en, input logic [1:0] md);
        int pc;
        pc = m_pc[k];
        m_last[k] = pc;
        exp_cd[k] = 1'b0;
        if (en !== 1'b1) begin
            exp_led[k] = '0; m_run[k] = 1'b0; m_idx[k] = 0; m_chase[k] = 0;
        end else begin
            for (int i = 0; i < N; i++) exp_led[k][i] = m_run[k] && (pc < chan_d(k, i));
            if (pc == PER - 1) begin
                if (!m_run[k]) begin
                    m_run[k] = 1'b1; m_idx[k] = 0; m_mode[k] = md;
                end else begin
                    m_idx[k]++;
                    if (m_idx[k] > 1 && (m_idx[k] - 1) % clen[k] == 0) begin
                        exp_cd[k] = 1'b1;
                        m_chase[k] = (m_chase[k] + 1) % N;
                        m_mode[k] = md;
                    end
                end
            end
        end
        exp_ph[k] = m_run[k] ? 3'(cur_ph(k)) : 3'd0;
        m_pc[k] = (pc + 1) % PER;
    endtask

    function automatic logic [VW-1:0] expv();
        return {exp_led[0], exp_ph[0], exp_cd[0], exp_led[1], exp_ph[1], exp_cd[1]};
    endfunction

    // Advance one clk: inputs are stable at posedge, outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        model_step(0, en0, md0);
        model_step(1, en1, md1);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #11;
        checks++;
        if (act !== '0) begin
            errors++; $display("FAIL reset_state got %h want 0", act);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_inphase();
        int ht = 0;
        int last_cd = -1;
        int hts[$];
        int want[11] = '{2, 6, 10, 14, 14, 10, 6, 2, 2, 6, 10};
        md0 = 2'd0; en0 = 1'b1;
        for (int c = 0; c < 30 * PER; c++) begin
            tick();
            checks++;
            if (act !== expv()) begin
                errors++; $display("FAIL inphase t=%0t got %h want %h", $time, act, expv());
            end
            if (led0[0]) ht++;
            if (m_last[0] == PER - 1) begin
                if (ht > 0) hts.push_back(ht);
                ht = 0;
            end
            if (cd0) begin
                if (last_cd >= 0) begin
                    checks++;
                    if (c - last_cd != 8 * PER) begin
                        errors++; $display("FAIL inphase_cd_interval got %0d want %0d", c - last_cd, 8 * PER);
                    end
                end
                last_cd = c;
            end
        end
        checks++;
        if (hts.size() < 11) begin
            errors++; $display("FAIL inphase_periods got %0d want >=11", hts.size());
        end
        for (int i = 0; i < 11 && i < hts.size(); i++) begin
            checks++;
            if (hts[i] != want[i]) begin
                errors++; $display("FAIL inphase_hightime[%0d] got %0d want %0d", i, hts[i], want[i]);
            end
        end
        en0 = 1'b0; tick();
    endtask

    task automatic test_split();
        int lo = 0, hi = 0, pairs = 0;
        md0 = 2'd1; en0 = 1'b1;
        repeat (27 * PER) begin
            tick();
            checks++;
            if (act !== expv()) begin
                errors++; $display("FAIL split t=%0t got %h want %h", $time, act, expv());
            end
            if (led0[0]) lo++;
            if (led0[N-1]) hi++;
            if (m_last[0] == PER - 1) begin
                if (lo == 6 || lo == 14) begin
                    pairs++; checks++;
                    if (hi != ((lo == 6) ? 10 : 2)) begin
                        errors++; $display("FAIL split_pair lo=%0d got hi %0d want %0d", lo, hi, (lo == 6) ? 10 : 2);
                    end
                end
                lo = 0; hi = 0;
            end
        end
        checks++;
        if (pairs < 6) begin
            errors++; $display("FAIL split_pair_count got %0d want >=6", pairs);
        end
        en0 = 1'b0; tick();
    endtask

    task automatic test_chase();
        logic [N-1:0] seen = '0;
        logic [N-1:0] one = 1;
        int ncd = 0;
        md0 = 2'd2; en0 = 1'b1;
        repeat (80 * PER) begin
            tick();
            checks++;
            if (act !== expv() || $countones(led0) > 1) begin
                errors++; $display("FAIL chase t=%0t got %h want %h", $time, act, expv());
            end
            seen |= led0;
            if (cd0) begin
                checks++;
                if (seen !== (one << (ncd % N))) begin
                    errors++; $display("FAIL chase_index breath %0d got %b want %b", ncd, seen, one << (ncd % N));
                end
                ncd++; seen = '0;
            end
        end
        checks++;
        if (ncd < 9) begin
            errors++; $display("FAIL chase_wrap cycle_done count got %0d want >=9", ncd);
        end
        en0 = 1'b0; tick();
    endtask

    task automatic test_enable_drop();
        int n = 0;
        int ht;
        md0 = 2'd0; en0 = 1'b1;
        while (ph0 !== 3'd1 && n < 4 * PER) begin
            tick(); n++;
            checks++;
            if (act !== expv()) begin errors++; $display("FAIL drop_pre got %h want %h", act, expv()); end
        end
        checks++;
        if (ph0 !== 3'd1) begin errors++; $display("FAIL drop_wait_rampup phase %0d want 1", ph0); end
        while (m_pc[0] != 8) begin
            tick();
            checks++;
            if (act !== expv()) begin errors++; $display("FAIL drop_mid got %h want %h", act, expv()); end
        end
        en0 = 1'b0;
        tick();
        checks++;
        if (led0 !== '0 || ph0 !== 3'd0) begin
            errors++; $display("FAIL drop_off led %b phase %0d want 0 0", led0, ph0);
        end
        en0 = 1'b1; n = 0;
        while (led0[0] !== 1'b1 && n < 3 * PER) begin
            tick(); n++;
            checks++;
            if (act !== expv()) begin errors++; $display("FAIL drop_re got %h want %h", act, expv()); end
        end
        checks++;
        if (led0[0] !== 1'b1 || m_last[0] != 0) begin
            errors++; $display("FAIL drop_relit led %b pcount %0d want lit at 0", led0[0], m_last[0]);
        end
        ht = 1;
        while (m_last[0] != PER - 1) begin
            tick();
            if (led0[0]) ht++;
        end
        checks++;
        if (ht != MN) begin errors++; $display("FAIL drop_first_duty got %0d want %0d", ht, MN); end
        en0 = 1'b0; tick();
    endtask

    task automatic test_step5();
        int lo = 0, hi = 0, n = 0;
        int los[$];
        int his[$];
        int want_lo[12] = '{2, 7, 12, 14, 14, 9, 4, 2, 2, 7, 12, 14};
        int want_hi[12] = '{2, 7, 12, 14, 14, 9, 4, 2, 2, 9, 4, 2};
        md1 = 2'd0; en1 = 1'b1;
        while (los.size() < 12 && n < 20 * PER) begin
            tick(); n++;
            checks++;
            if (act !== expv()) begin errors++; $display("FAIL step5 t=%0t got %h want %h", $time, act, expv()); end
            if (led1[0]) lo++;
            if (led1[N-1]) hi++;
            if (m_last[1] == PER - 1) begin
                if (lo > 0) begin los.push_back(lo); his.push_back(hi); end
                lo = 0; hi = 0;
                if (los.size() == 2) md1 = 2'd1;
            end
        end
        checks++;
        if (los.size() != 12) begin errors++; $display("FAIL step5_periods got %0d want 12", los.size()); end
        for (int i = 0; i < los.size(); i++) begin
            checks++;
            if (los[i] != want_lo[i] || his[i] != want_hi[i]) begin
                errors++;
                $display("FAIL step5_hightime[%0d] got %0d/%0d want %0d/%0d", i, los[i], his[i], want_lo[i], want_hi[i]);
            end
        end
        en1 = 1'b0; tick();
    endtask

    task automatic test_async_reset();
        int n = 0;
        md0 = 2'd0; en0 = 1'b1;
        while (ph0 !== 3'd3 && n < 12 * PER) begin
            tick(); n++;
            checks++;
            if (act !== expv()) begin errors++; $display("FAIL areset_pre got %h want %h", act, expv()); end
        end
        checks++;
        if (ph0 !== 3'd3) begin errors++; $display("FAIL areset_wait_rampdown phase %0d want 3", ph0); end
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (led0 !== '0 || ph0 !== 3'd0 || cd0 !== 1'b0) begin
            errors++; $display("FAIL areset_immediate led %b phase %0d want 0 0", led0, ph0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4 * PER) begin
            tick();
            checks++;
            if (act !== expv()) begin errors++; $display("FAIL areset_restart t=%0t got %h want %h", $time, act, expv()); end
        end
        en0 = 1'b0; tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            if (en0) begin if ($urandom_range(0, 399) == 0) en0 = 1'b0; end
            else if ($urandom_range(0, 15) == 0) en0 = 1'b1;
            if (en1) begin if ($urandom_range(0, 399) == 0) en1 = 1'b0; end
            else if ($urandom_range(0, 15) == 0) en1 = 1'b1;
            if ($urandom_range(0, 99) == 0) md0 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) md1 = 2'($urandom_range(0, 3));
            tick();
            checks++;
            if (act !== expv()) begin errors++; $display("FAIL random t=%0t got %h want %h", $time, act, expv()); end
        end
    endtask

    initial begin
        build_profile(0);
        build_profile(1);
        model_reset();
        test_reset();
        test_inphase();
        test_split();
        test_chase();
        test_enable_drop();
        test_step5();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
